// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word/register widths, ALU opcodes, operand/destination
// selects, and the ID/EX pipeline bundle.
package cpu_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;

  typedef enum logic [3:0] {
    ALU_SLL  = 4'd0,
    ALU_SRL  = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_SUB  = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_NOR  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } aluop_t;

  typedef enum logic [1:0] {
    SRC_RDAT2 = 2'd0,
    SRC_IMM   = 2'd1,
    SRC_SHAMT = 2'd2
  } alusrc_t;

  typedef enum logic [1:0] {
    DST_RT  = 2'd0,
    DST_RD  = 2'd1,
    DST_R31 = 2'd2
  } regdst_t;

  typedef struct packed {
    logic     valid;
    word_t    imm;
    word_t    rdat1;
    word_t    rdat2;
    word_t    npc;
    regbits_t shamt;
    regbits_t rs;
    regbits_t rt;
    regbits_t rd;
    aluop_t   aluop;
    alusrc_t  alusrc;
    regdst_t  regdst;
    logic     regwr;
    logic     memrd;
    logic     memwr;
    logic     memtoreg;
    logic     jal;
    logic     halt;
  } id_ex_t;

  // All-zero bundle: empty slot, aluop decodes as ALU_SLL.
  localparam id_ex_t ID_EX_NOP = '0;

endpackage

// File: rtl/id_ex_latch.sv
// ID/EX pipeline register. Holds the decoded bundle for the execute stage,
// with hold (en_i=0), squash (flush_i) and load-use bubble insertion.
module id_ex_latch
  import cpu_types_pkg::*;
(
  input  logic        CLK,
  input  logic        nRST,
  input  logic        en_i,
  input  logic        flush_i,
  input  logic        bubble_i,
  input  logic        id_valid_i,
  input  logic [31:0] id_imm_i,
  input  logic [31:0] id_rdat1_i,
  input  logic [31:0] id_rdat2_i,
  input  logic [31:0] id_npc_i,
  input  logic [4:0]  id_shamt_i,
  input  logic [4:0]  id_rs_i,
  input  logic [4:0]  id_rt_i,
  input  logic [4:0]  id_rd_i,
  input  logic [3:0]  id_aluop_i,
  input  logic [1:0]  id_alusrc_i,
  input  logic [1:0]  id_regdst_i,
  input  logic        id_regwr_i,
  input  logic        id_memrd_i,
  input  logic        id_memwr_i,
  input  logic        id_memtoreg_i,
  input  logic        id_jal_i,
  input  logic        id_halt_i,
  output logic        ex_valid_o,
  output logic [31:0] ex_imm_o,
  output logic [31:0] ex_rdat1_o,
  output logic [31:0] ex_rdat2_o,
  output logic [31:0] ex_npc_o,
  output logic [4:0]  ex_shamt_o,
  output logic [4:0]  ex_rs_o,
  output logic [4:0]  ex_rt_o,
  output logic [4:0]  ex_rd_o,
  output logic [3:0]  ex_aluop_o,
  output logic [1:0]  ex_alusrc_o,
  output logic [1:0]  ex_regdst_o,
  output logic        ex_regwr_o,
  output logic        ex_memrd_o,
  output logic        ex_memwr_o,
  output logic        ex_memtoreg_o,
  output logic        ex_jal_o,
  output logic        ex_halt_o
);

  id_ex_t id_s;
  id_ex_t ex_d;
  id_ex_t ex_q;

  // Pack decode-side ports into one bundle; side-effecting controls are
  // masked by valid so a non-instruction can never write or halt.
  always_comb begin
    id_s          = ID_EX_NOP;
    id_s.valid    = id_valid_i;
    id_s.imm      = id_imm_i;
    id_s.rdat1    = id_rdat1_i;
    id_s.rdat2    = id_rdat2_i;
    id_s.npc      = id_npc_i;
    id_s.shamt    = id_shamt_i;
    id_s.rs       = id_rs_i;
    id_s.rt       = id_rt_i;
    id_s.rd       = id_rd_i;
    id_s.aluop    = aluop_t'(id_aluop_i);
    id_s.alusrc   = alusrc_t'(id_alusrc_i);
    id_s.regdst   = regdst_t'(id_regdst_i);
    id_s.regwr    = id_regwr_i & id_valid_i;
    id_s.memrd    = id_memrd_i;
    id_s.memwr    = id_memwr_i & id_valid_i;
    id_s.memtoreg = id_memtoreg_i;
    id_s.jal      = id_jal_i;
    id_s.halt     = id_halt_i & id_valid_i;
  end

  // Next-state mux: flush beats bubble beats load; otherwise hold.
  // A bubble zeroes specifiers too so forwarding never sees stale rs/rt.
  always_comb begin
    ex_d = ex_q;
    if (flush_i) begin
      ex_d = ID_EX_NOP;
    end else if (en_i && bubble_i) begin
      ex_d = ID_EX_NOP;
    end else if (en_i) begin
      ex_d = id_s;
    end
  end

  // Bundle register with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      ex_q <= ID_EX_NOP;
    end else begin
      ex_q <= ex_d;
    end
  end

  assign ex_valid_o    = ex_q.valid;
  assign ex_imm_o      = ex_q.imm;
  assign ex_rdat1_o    = ex_q.rdat1;
  assign ex_rdat2_o    = ex_q.rdat2;
  assign ex_npc_o      = ex_q.npc;
  assign ex_shamt_o    = ex_q.shamt;
  assign ex_rs_o       = ex_q.rs;
  assign ex_rt_o       = ex_q.rt;
  assign ex_rd_o       = ex_q.rd;
  assign ex_aluop_o    = ex_q.aluop;
  assign ex_alusrc_o   = ex_q.alusrc;
  assign ex_regdst_o   = ex_q.regdst;
  assign ex_regwr_o    = ex_q.regwr;
  assign ex_memrd_o    = ex_q.memrd;
  assign ex_memwr_o    = ex_q.memwr;
  assign ex_memtoreg_o = ex_q.memtoreg;
  assign ex_jal_o      = ex_q.jal;
  assign ex_halt_o     = ex_q.halt;

endmodule

// File: tb/tb_id_ex_latch.sv
// Directed vector bench for the ID/EX pipeline register.
module tb_id_ex_latch;
  import cpu_types_pkg::*;

  logic   clk_s = 1'b0;
  logic   nrst_s;
  logic   en_s, flush_s, bubble_s;
  id_ex_t drv_s;
  id_ex_t got_s;

  logic        ex_valid, ex_regwr, ex_memrd, ex_memwr, ex_memtoreg, ex_jal, ex_halt;
  logic [31:0] ex_imm, ex_rdat1, ex_rdat2, ex_npc;
  logic [4:0]  ex_shamt, ex_rs, ex_rt, ex_rd;
  logic [3:0]  ex_aluop;
  logic [1:0]  ex_alusrc, ex_regdst;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk_s = ~clk_s;

  id_ex_latch dut (
    .CLK(clk_s), .nRST(nrst_s), .en_i(en_s), .flush_i(flush_s), .bubble_i(bubble_s),
    .id_valid_i(drv_s.valid), .id_imm_i(drv_s.imm), .id_rdat1_i(drv_s.rdat1),
    .id_rdat2_i(drv_s.rdat2), .id_npc_i(drv_s.npc), .id_shamt_i(drv_s.shamt),
    .id_rs_i(drv_s.rs), .id_rt_i(drv_s.rt), .id_rd_i(drv_s.rd),
    .id_aluop_i(drv_s.aluop), .id_alusrc_i(drv_s.alusrc), .id_regdst_i(drv_s.regdst),
    .id_regwr_i(drv_s.regwr), .id_memrd_i(drv_s.memrd), .id_memwr_i(drv_s.memwr),
    .id_memtoreg_i(drv_s.memtoreg), .id_jal_i(drv_s.jal), .id_halt_i(drv_s.halt),
    .ex_valid_o(ex_valid), .ex_imm_o(ex_imm), .ex_rdat1_o(ex_rdat1),
    .ex_rdat2_o(ex_rdat2), .ex_npc_o(ex_npc), .ex_shamt_o(ex_shamt),
    .ex_rs_o(ex_rs), .ex_rt_o(ex_rt), .ex_rd_o(ex_rd),
    .ex_aluop_o(ex_aluop), .ex_alusrc_o(ex_alusrc), .ex_regdst_o(ex_regdst),
    .ex_regwr_o(ex_regwr), .ex_memrd_o(ex_memrd), .ex_memwr_o(ex_memwr),
    .ex_memtoreg_o(ex_memtoreg), .ex_jal_o(ex_jal), .ex_halt_o(ex_halt)
  );

  always_comb begin
    got_s          = '0;
    got_s.valid    = ex_valid;
    got_s.imm      = ex_imm;
    got_s.rdat1    = ex_rdat1;
    got_s.rdat2    = ex_rdat2;
    got_s.npc      = ex_npc;
    got_s.shamt    = ex_shamt;
    got_s.rs       = ex_rs;
    got_s.rt       = ex_rt;
    got_s.rd       = ex_rd;
    got_s.aluop    = aluop_t'(ex_aluop);
    got_s.alusrc   = alusrc_t'(ex_alusrc);
    got_s.regdst   = regdst_t'(ex_regdst);
    got_s.regwr    = ex_regwr;
    got_s.memrd    = ex_memrd;
    got_s.memwr    = ex_memwr;
    got_s.memtoreg = ex_memtoreg;
    got_s.jal      = ex_jal;
    got_s.halt     = ex_halt;
  end

  // Bundle builder: the named fields are explicit, the rest derive from seed
  // so every field carries a distinct, recognisable value.
  function automatic id_ex_t mk(logic v, word_t imm, word_t r1, logic [7:0] seed,
                                aluop_t op, logic regwr, logic memrd, logic memwr,
                                logic halt, regbits_t rt);
    id_ex_t b;
    b.valid    = v;
    b.imm      = imm;
    b.rdat1    = r1;
    b.rdat2    = {24'hA5A5A5, seed};
    b.npc      = {24'h004000, seed};
    b.shamt    = seed[4:0];
    b.rs       = ~seed[4:0];
    b.rt       = rt;
    b.rd       = seed[4:0] + 5'd1;
    b.aluop    = op;
    b.alusrc   = SRC_SHAMT;
    b.regdst   = DST_RD;
    b.regwr    = regwr;
    b.memrd    = memrd;
    b.memwr    = memwr;
    b.memtoreg = 1'b1;
    b.jal      = seed[0];
    b.halt     = halt;
    return b;
  endfunction

  typedef struct {
    logic   rst_b;
    logic   en;
    logic   flush;
    logic   bubble;
    id_ex_t din;
    id_ex_t exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(logic r, logic e, logic f, logic b, id_ex_t din, id_ex_t exp);
    vec_t v;
    v.rst_b = r; v.en = e; v.flush = f; v.bubble = b; v.din = din; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic check(string name, id_ex_t exp);
    n_checks++;
    if (got_s === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, got_s, exp);
  endtask

  task automatic step(logic r, logic e, logic f, logic b, id_ex_t din);
    nrst_s = r; en_s = e; flush_s = f; bubble_s = b; drv_s = din;
    @(posedge clk_s);
    #1;
  endtask

  id_ex_t ones, va, vb, vc, vd_in, vd_exp, ve, vf, vg;

  initial begin
    ones   = '1;
    va     = mk(1, 32'hFFFF8000, 32'h12, 8'h11, ALU_ADD, 1, 0, 0, 0, 5'd3);
    vb     = mk(1, 32'h00010000, 32'h34, 8'h22, ALU_SUB, 1, 0, 0, 0, 5'd4);
    vc     = mk(1, 32'h0000_00C8, 32'h56, 8'h33, ALU_OR,  0, 0, 1, 0, 5'd9);
    vd_in  = mk(0, 32'hDEAD_BEEF, 32'h78, 8'h44, ALU_SLT, 1, 1, 1, 1, 5'd10);
    vd_exp = mk(0, 32'hDEAD_BEEF, 32'h78, 8'h44, ALU_SLT, 0, 1, 0, 0, 5'd10);
    ve     = mk(1, 32'h0000_0001, 32'h9A, 8'h55, ALU_XOR, 1, 0, 1, 1, 5'd11);
    vf     = mk(1, 32'h8000_0000, 32'hFFFF_FFFF, 8'h66, ALU_SLTU, 1, 1, 0, 0, 5'd31);
    vg     = mk(1, 32'h1234_5678, 32'hCAFE, 8'h77, ALU_NOR, 1, 0, 0, 0, 5'd7);

    //  rst en fl bu  input   expected after the edge
    add(0, 1, 0, 0, ones,   ID_EX_NOP);  // reset, inputs all-ones
    add(0, 1, 0, 0, ones,   ID_EX_NOP);
    add(1, 1, 0, 0, va,     va);         // load
    add(1, 0, 0, 0, vb,     va);         // stall x3, inputs changed
    add(1, 0, 0, 0, vb,     va);
    add(1, 0, 0, 0, vb,     va);
    add(1, 1, 0, 0, vb,     vb);         // released
    add(1, 1, 0, 1, mk(1, 32'h5, 32'h6, 8'h12, ALU_AND, 1, 1, 0, 0, 5'd8), ID_EX_NOP);
    add(1, 1, 0, 0, vc,     vc);         // load memwr
    add(1, 0, 0, 1, vb,     vc);         // bubble without en holds
    add(1, 0, 1, 1, vb,     ID_EX_NOP);  // flush beats en=0 and bubble
    add(1, 1, 0, 0, vd_in,  vd_exp);     // invalid: regwr/memwr/halt masked
    add(1, 1, 0, 0, ve,     ve);         // valid halt passes
    add(1, 0, 0, 0, vf,     ve);         // stall
    add(0, 0, 0, 0, vf,     ID_EX_NOP);  // reset mid-stall
    add(1, 1, 1, 1, vf,     ID_EX_NOP);  // flush with en and bubble
    add(1, 1, 1, 0, vf,     ID_EX_NOP);  // flush with plain load
    add(1, 1, 0, 0, vf,     vf);
    add(1, 0, 1, 0, vb,     ID_EX_NOP);  // flush while stalled
    add(1, 1, 0, 0, vb,     vb);

    nrst_s = 0; en_s = 0; flush_s = 0; bubble_s = 0; drv_s = '0;
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst_b, vecs[i].en, vecs[i].flush, vecs[i].bubble, vecs[i].din);
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Long stall with inputs changing every cycle: output must not move.
    step(1, 1, 0, 0, vg);
    check("stall_load", vg);
    for (int k = 0; k < 6; k++) begin
      step(1, 0, 0, k[0], mk(k[1], 32'(k * 32'h1111), 32'(k), 8'(k + 8'h80),
                             ALU_SRL, 1, 1, 1, 1, 5'(k)));
      check($sformatf("stall_hold%0d", k), vg);
    end
    step(1, 1, 0, 0, va);
    check("stall_release", va);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish required finish");
    $fatal(1);
  end

endmodule
